clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 139 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Divisor-switch controller for an even clock divider: arbitrates two requesters and
// resets the divider at a low phase. Optional WAIT_LOW watchdog under DIV_CTRL_TIMEOUT_EN.
module clk_div_ctrl #(
  parameter int WIDTH_NUM_DIV = 4,
  parameter int DEFAULT_DIV   = 4,
  parameter int SETTLE_CYC    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_a_valid,
  input  logic [WIDTH_NUM_DIV-1:0] req_a_num_div,
  output logic                     req_a_ready,
  input  logic                     req_b_valid,
  input  logic [WIDTH_NUM_DIV-1:0] req_b_num_div,
  output logic                     req_b_ready,
  input  logic                     clk_div_in,
  output logic [WIDTH_NUM_DIV-1:0] num_div_out,
  output logic                     div_rst_n,
  output logic                     busy,
  output logic                     done,
  output logic                     err_inval,
  output logic                     timeout
);
  typedef enum logic [2:0] {IDLE, WAIT_LOW, HOLD, SETTLE, DONE} state_t;

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [WIDTH_NUM_DIV-1:0] DIV_RST = WIDTH_NUM_DIV'(DEFAULT_DIV);
  localparam logic [WIDTH_NUM_DIV-1:0] DIV_MIN = WIDTH_NUM_DIV'(2);

  state_t                   state;
  logic [WIDTH_NUM_DIV-1:0] pend;
  logic                     rr_b;
  logic                     clk_div_q;
  logic [CW-1:0]            set_cnt;
  logic                     idle, gnt_a, gnt_b, fall, req_bad;
  logic [WIDTH_NUM_DIV-1:0] req_num;

  // rr_b set means B holds priority on the next contended cycle
  assign idle    = rst_n && (state == IDLE);
  assign gnt_a   = idle && req_a_valid && (!req_b_valid || !rr_b);
  assign gnt_b   = idle && req_b_valid && (!req_a_valid || rr_b);
  assign req_num = gnt_a ? req_a_num_div : req_b_num_div;
  assign req_bad = req_num[0] || (req_num < DIV_MIN);
  assign fall    = clk_div_q && !clk_div_in;

  assign req_a_ready = gnt_a;
  assign req_b_ready = gnt_b;

`ifdef DIV_CTRL_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= DIV_RST;
      num_div_out <= DIV_RST;
      div_rst_n   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_inval   <= 1'b0;
      rr_b        <= 1'b0;
      clk_div_q   <= 1'b0;
      set_cnt     <= '0;
`ifdef DIV_CTRL_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      clk_div_q <= clk_div_in;
      done      <= 1'b0;
      err_inval <= 1'b0;
`ifdef DIV_CTRL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          div_rst_n <= 1'b1;
          if (gnt_a || gnt_b) begin
            pend <= req_num;
            rr_b <= gnt_a;
            if (req_bad)                   err_inval <= 1'b1;
            else if (req_num == num_div_out) done    <= 1'b1;
            else begin
              state <= WAIT_LOW;
              busy  <= 1'b1;
`ifdef DIV_CTRL_TIMEOUT_EN
              wd_cnt <= '0;
`endif
            end
          end
        end
        WAIT_LOW: begin
          if (fall) begin
            state       <= HOLD;
            div_rst_n   <= 1'b0;
            num_div_out <= pend;
          end
`ifdef DIV_CTRL_TIMEOUT_EN
          else if (wd_cnt == 8'd254) begin
            state       <= HOLD;
            div_rst_n   <= 1'b0;
            num_div_out <= pend;
            timeout_q   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`endif
        end
        HOLD: begin
          state     <= SETTLE;
          div_rst_n <= 1'b1;
          set_cnt   <= '0;
        end
        SETTLE: begin
          if (set_cnt == SETTLE_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: clk_div_in is driven by hand so every latency is fixed.
module tb_clk_div_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a_valid, req_b_valid;
  logic [3:0] req_a_num_div, req_b_num_div;
  logic       req_a_ready, req_b_ready;
  logic       clk_div_in;
  logic [3:0] num_div_out;
  logic       div_rst_n, busy, done, err_inval, timeout;

  int n_chk = 0;
  int n_fail = 0;
  int n;
  logic saw_done;

  always #5 clk = ~clk;

  clk_div_ctrl #(.WIDTH_NUM_DIV(4), .DEFAULT_DIV(4), .SETTLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(req_a_valid), .req_a_num_div(req_a_num_div), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_num_div(req_b_num_div), .req_b_ready(req_b_ready),
    .clk_div_in(clk_div_in), .num_div_out(num_div_out), .div_rst_n(div_rst_n),
    .busy(busy), .done(done), .err_inval(err_inval), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // counts negedges until done is seen, bounded
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_a_valid = 1'b1; req_b_valid = 1'b0;
    req_a_num_div = 4'd8; req_b_num_div = 4'd0; clk_div_in = 1'b1;

    // reset state, ready gated while in reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_a", 32'(req_a_ready), 0);
    chk("rst_num", 32'(num_div_out), 4);
    chk("rst_div_rst_n", 32'(div_rst_n), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_inval), 0);
    chk("rst_timeout", 32'(timeout), 0);
    req_a_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_div_rst_n", 32'(div_rst_n), 1);

    // A requests 8, one-cycle fall right after acceptance
    req_a_valid = 1'b1; req_a_num_div = 4'd8; clk_div_in = 1'b1;
    #1 chk("t1_ready_a", 32'(req_a_ready), 1);
    @(negedge clk);
    req_a_valid = 1'b0;
    #1 chk("t1_ready_a_drop", 32'(req_a_ready), 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_num_wait", 32'(num_div_out), 4);
    clk_div_in = 1'b0;
    @(negedge clk);
    chk("t1_hold_num", 32'(num_div_out), 8);
    chk("t1_hold_rst", 32'(div_rst_n), 0);
    @(negedge clk);
    chk("t1_settle_rst", 32'(div_rst_n), 1);
    repeat (3) @(negedge clk);
    chk("t1_settle_end_done", 32'(done), 0);
    @(negedge clk);
    chk("t1_done", 32'(done), 1);
    chk("t1_done_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t1_idle_done", 32'(done), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // both valid: A first, then B, then pointer favours A again
    do_reset();
    req_a_valid = 1'b1; req_a_num_div = 4'd6;
    req_b_valid = 1'b1; req_b_num_div = 4'd10;
    clk_div_in = 1'b1;
    #1 chk("t2_ready_a", 32'(req_a_ready), 1);
    chk("t2_ready_b", 32'(req_b_ready), 0);
    @(negedge clk);
    req_a_valid = 1'b0; clk_div_in = 1'b0;
    #1 chk("t2_busy_ready_b", 32'(req_b_ready), 0);
    wait_done(n);
    chk("t2_a_latency", 32'(n), 6);
    chk("t2_a_num", 32'(num_div_out), 6);
    clk_div_in = 1'b1;
    @(negedge clk);
    #1 chk("t2_ready_b_idle", 32'(req_b_ready), 1);
    chk("t2_ready_a_idle", 32'(req_a_ready), 0);
    @(negedge clk);
    req_b_valid = 1'b0; clk_div_in = 1'b0;
    wait_done(n);
    chk("t2_b_latency", 32'(n), 6);
    chk("t2_b_num", 32'(num_div_out), 10);
    req_a_valid = 1'b1; req_a_num_div = 4'd10;
    req_b_valid = 1'b1; req_b_num_div = 4'd10;
    @(negedge clk);
    #1 chk("t2_rr_ready_a", 32'(req_a_ready), 1);
    chk("t2_rr_ready_b", 32'(req_b_ready), 0);
    @(negedge clk);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    chk("t2_rr_same_done", 32'(done), 1);

    // invalid divisors 5 and 0 from B
    do_reset();
    req_b_valid = 1'b1; req_b_num_div = 4'd5;
    #1 chk("t3_ready_b5", 32'(req_b_ready), 1);
    @(negedge clk);
    chk("t3_err5", 32'(err_inval), 1);
    chk("t3_busy5", 32'(busy), 0);
    chk("t3_num5", 32'(num_div_out), 4);
    req_b_num_div = 4'd0;
    #1 chk("t3_ready_b0", 32'(req_b_ready), 1);
    @(negedge clk);
    req_b_valid = 1'b0;
    chk("t3_err0", 32'(err_inval), 1);
    chk("t3_busy0", 32'(busy), 0);
    chk("t3_num0", 32'(num_div_out), 4);
    @(negedge clk);
    chk("t3_err_clear", 32'(err_inval), 0);

    // same divisor: immediate done, divider not reset
    req_a_valid = 1'b1; req_a_num_div = 4'd4;
    @(negedge clk);
    req_a_valid = 1'b0;
    chk("t4_done", 32'(done), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_div_rst_n", 32'(div_rst_n), 1);
    @(negedge clk);
    chk("t4_done_clear", 32'(done), 0);
    chk("t4_div_rst_n2", 32'(div_rst_n), 1);

    // reset during SETTLE of a switch to 12
    req_a_valid = 1'b1; req_a_num_div = 4'd12; clk_div_in = 1'b1;
    @(negedge clk);
    req_a_valid = 1'b0; clk_div_in = 1'b0;
    @(negedge clk);
    chk("t5_hold_num", 32'(num_div_out), 12);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_num", 32'(num_div_out), 4);
    chk("t5_rst_div", 32'(div_rst_n), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("t5_no_done", 32'(saw_done), 0);
    chk("t5_num_after", 32'(num_div_out), 4);

    // clk_div_in stuck low
    do_reset();
    clk_div_in = 1'b0;
    req_a_valid = 1'b1; req_a_num_div = 4'd8;
    @(negedge clk);
    req_a_valid = 1'b0;
`ifdef DIV_CTRL_TIMEOUT_EN
    n = 0;
    while (timeout !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t6_timeout_cycles", 32'(n), 255);
    chk("t6_timeout_num", 32'(num_div_out), 8);
    chk("t6_timeout_rst", 32'(div_rst_n), 0);
    wait_done(n);
    chk("t6_done_latency", 32'(n), 5);
`else
    repeat (300) @(negedge clk);
    chk("t6_stuck_busy", 32'(busy), 1);
    chk("t6_stuck_num", 32'(num_div_out), 4);
    chk("t6_stuck_timeout", 32'(timeout), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
